// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial pattern transmitter with golden "101"/"110" detector model
// Shifts a W-bit word out MSB-first, then forces GAP idle cycles before the next accept.
module seq_gen #(
  parameter int W   = 8,
  parameter int GAP = 2,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  output logic          out,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic          exp_hit,
  output logic [CW-1:0] exp_count
);

  localparam int CNTW = $clog2(W + 1);
  localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(W - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [1:0] M_S0  = 2'd0;
  localparam logic [1:0] M_S1  = 2'd1;
  localparam logic [1:0] M_S10 = 2'd2;
  localparam logic [1:0] M_S11 = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CNTW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;
  logic [1:0]      model_q, model_d;
  logic [CW-1:0]   exp_count_q, exp_count_d;

  assign exp_hit = ((model_q == M_S10) && out_q) || ((model_q == M_S11) && !out_q);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    exp_count_d = exp_count_q;

    case (state_q)
      ST_IDLE: begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        if (load_valid) begin
          state_d     = ST_SHIFT;
          out_d       = load_data[W-1];
          out_valid_d = 1'b1;
          shreg_d     = {load_data[W-2:0], 1'b0};
          bit_cnt_d   = '0;
          exp_count_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          out_d       = 1'b0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          gap_cnt_d   = '0;
          state_d     = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          out_d     = shreg_q[W-1];
          shreg_d   = {shreg_q[W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only hits on frame bits are counted; idle/gap hits still move the model.
    if ((state_q == ST_SHIFT) && exp_hit && (exp_count_q != {CW{1'b1}})) begin
      exp_count_d = exp_count_q + 1'b1;
    end
  end

  always_comb begin
    model_d = M_S0;
    case (model_q)
      M_S0:    model_d = out_q ? M_S1  : M_S0;
      M_S1:    model_d = out_q ? M_S11 : M_S10;
      M_S10:   model_d = out_q ? M_S1  : M_S0;
      M_S11:   model_d = out_q ? M_S11 : M_S0;
      default: model_d = M_S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      model_q     <= M_S0;
      exp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      model_q     <= model_d;
      exp_count_q <= exp_count_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign exp_count  = exp_count_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - self-checking bench for seq_gen (three parameterisations)
// Table vectors, hand-written corner sequences and a randomized run against a frame/window model.
module tb_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic lv0 = 1'b0, lv1 = 1'b0, lv2 = 1'b0;
  logic [7:0]  d0 = '0, d1 = '0;
  logic [15:0] d2 = '0;

  logic r0, o0, ov0, b0, dn0, h0;
  logic r1, o1, ov1, b1, dn1, h1;
  logic r2, o2, ov2, b2, dn2, h2;
  logic [3:0] c0, c1;
  logic [1:0] c2;

  seq_gen #(.W(8), .GAP(2), .CW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_ready(r0), .load_data(d0),
    .out(o0), .out_valid(ov0), .busy(b0), .done(dn0), .exp_hit(h0), .exp_count(c0));
  seq_gen #(.W(8), .GAP(0), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(r1), .load_data(d1),
    .out(o1), .out_valid(ov1), .busy(b1), .done(dn1), .exp_hit(h1), .exp_count(c1));
  seq_gen #(.W(16), .GAP(2), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(r2), .load_data(d2),
    .out(o2), .out_valid(ov2), .busy(b2), .done(dn2), .exp_hit(h2), .exp_count(c2));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: a frame is a timeline t=1..W of bits, t=W+1 the done cycle, t<=W+GAP busy.
  // The detector is a sliding window of the last two unconsumed bits.
  int          w_a[3]    = '{8, 8, 16};
  int          gap_a[3]  = '{2, 0, 2};
  int          cmax_a[3] = '{15, 15, 3};
  int          t_m[3]    = '{0, 0, 0};
  bit          act_m[3]  = '{0, 0, 0};
  logic [15:0] word_m[3] = '{16'h0, 16'h0, 16'h0};
  int          hlen_m[3] = '{0, 0, 0};
  logic [1:0]  hist_m[3] = '{2'b00, 2'b00, 2'b00};
  int          cnt_m[3]  = '{0, 0, 0};

  function automatic logic m_valid(int i);
    return act_m[i] && (t_m[i] >= 1) && (t_m[i] <= w_a[i]);
  endfunction

  function automatic logic m_out(int i);
    if (m_valid(i)) return word_m[i][w_a[i] - t_m[i]];
    return 1'b0;
  endfunction

  function automatic logic m_busy(int i);
    return act_m[i] && (t_m[i] >= 1) && (t_m[i] <= w_a[i] + gap_a[i]);
  endfunction

  function automatic logic m_done(int i);
    return act_m[i] && (t_m[i] == w_a[i] + 1);
  endfunction

  function automatic logic m_hit(int i);
    logic b;
    b = m_out(i);
    if (hlen_m[i] < 2) return 1'b0;
    return ((hist_m[i] == 2'b10) && b) || ((hist_m[i] == 2'b11) && !b);
  endfunction

  task automatic m_step(input int i, input logic rst, input logic lv, input logic [15:0] d);
    logic b, h, acc;
    if (!rst) begin
      act_m[i] = 1'b0; t_m[i] = 0; hlen_m[i] = 0; hist_m[i] = 2'b00; cnt_m[i] = 0;
      return;
    end
    b   = m_out(i);
    h   = m_hit(i);
    acc = lv && !m_busy(i);
    if (h && m_valid(i) && (cnt_m[i] < cmax_a[i])) cnt_m[i]++;
    if (h) begin
      if (b) begin hist_m[i] = 2'b01; hlen_m[i] = 1; end
      else   begin hist_m[i] = 2'b00; hlen_m[i] = 0; end
    end else begin
      hist_m[i] = {hist_m[i][0], b};
      if (hlen_m[i] < 2) hlen_m[i]++;
    end
    if (acc) begin
      act_m[i] = 1'b1; t_m[i] = 1; word_m[i] = d; cnt_m[i] = 0;
    end else if (act_m[i]) begin
      t_m[i]++;
      if (t_m[i] > w_a[i] + gap_a[i] + 1) act_m[i] = 1'b0;
    end
  endtask

  task automatic chk_inst(input int i, input logic o, input logic ov, input logic b,
                          input logic dn, input logic r, input logic h, input int c);
    check($sformatf("model%0d.out", i), o, m_out(i));
    check($sformatf("model%0d.out_valid", i), ov, m_valid(i));
    check($sformatf("model%0d.busy", i), b, m_busy(i));
    check($sformatf("model%0d.load_ready", i), r, !m_busy(i));
    check($sformatf("model%0d.done", i), dn, m_done(i));
    check($sformatf("model%0d.exp_hit", i), h, m_hit(i));
    check($sformatf("model%0d.exp_count", i), c, cnt_m[i]);
  endtask

  always @(posedge clk) begin
    cyc++;
    m_step(0, rst_n, lv0, {8'h00, d0});
    m_step(1, rst_n, lv1, {8'h00, d1});
    m_step(2, rst_n, lv2, d2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk_inst(0, o0, ov0, b0, dn0, r0, h0, int'(c0));
      chk_inst(1, o1, ov1, b1, dn1, r1, h1, int'(c1));
      chk_inst(2, o2, ov2, b2, dn2, r2, h2, int'(c2));
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] hit_mask;
    int          count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hits;
    vecs[0] = '{8'b10110110, 16'((1 << 3) | (1 << 5) | (1 << 8)), 3};
    vecs[1] = '{8'b11010000, 16'(1 << 3), 1};
    vecs[2] = '{8'hFF,       16'(1 << 9), 0};
    vecs[3] = '{8'h00,       16'h0000, 0};
    vecs[4] = '{8'b01010101, 16'((1 << 4) | (1 << 6) | (1 << 8)), 3};
    vecs[5] = '{8'b11011011, 16'((1 << 3) | (1 << 6) | (1 << 9)), 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset.load_ready", r0, 1'b1);
    check("reset.out", o0, 1'b0);
    check("reset.exp_count", c0, 4'd0);

    // Frame vectors on the W=8, GAP=2 instance, each starting from an idle line.
    for (int v = 0; v < 6; v++) begin
      lv0 = 1'b1;
      d0  = vecs[v].data;
      @(posedge clk);
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        lv0 = 1'b0;
        check($sformatf("vec%0d.out c%0d", v, c), o0, (c <= 8) ? vecs[v].data[8 - c] : 1'b0);
        check($sformatf("vec%0d.out_valid c%0d", v, c), ov0, c <= 8);
        check($sformatf("vec%0d.exp_hit c%0d", v, c), h0, vecs[v].hit_mask[c]);
        check($sformatf("vec%0d.done c%0d", v, c), dn0, c == 9);
        check($sformatf("vec%0d.load_ready c%0d", v, c), r0, c >= 11);
        check($sformatf("vec%0d.busy c%0d", v, c), b0, c <= 10);
        if (c >= 9) check($sformatf("vec%0d.exp_count c%0d", v, c), c0, vecs[v].count);
      end
    end

    // Reset in the middle of a frame aborts it without a done pulse.
    lv0 = 1'b1;
    d0  = 8'b10110110;
    @(posedge clk);
    repeat (6) @(negedge clk);
    lv0 = 1'b0;
    check("midreset.count_before", c0, 4'd2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset.out", o0, 1'b0);
    check("midreset.out_valid", ov0, 1'b0);
    check("midreset.done", dn0, 1'b0);
    check("midreset.exp_count", c0, 4'd0);
    check("midreset.load_ready", r0, 1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("midreset.no_done", dn0, 1'b0);
      check("midreset.no_valid", ov0, 1'b0);
    end

    // GAP=0 with load_valid held: one idle cycle between frames, done on it.
    lv1 = 1'b1;
    d1  = 8'hA5;
    @(posedge clk);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      check($sformatf("gap0.load_ready c%0d", c), r1, (c % 9) == 0);
      check($sformatf("gap0.out_valid c%0d", c), ov1, (c % 9) != 0);
      check($sformatf("gap0.done c%0d", c), dn1, (c % 9) == 0);
      if ((c % 9) == 0) check($sformatf("gap0.out c%0d", c), o1, 1'b0);
    end
    lv1 = 1'b0;
    repeat (10) @(negedge clk);

    // W=16, CW=2: seven hits on 16'hAAAA, count saturates at 3.
    lv2  = 1'b1;
    d2   = 16'hAAAA;
    hits = 0;
    @(posedge clk);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      lv2 = 1'b0;
      check($sformatf("sat.exp_count c%0d", c), c2, (hits > 3) ? 3 : hits);
      check($sformatf("sat.exp_hit c%0d", c), h2, (c >= 3) && (c <= 15) && (c % 2 == 1));
      if ((c >= 3) && (c <= 15) && (c % 2 == 1)) hits++;
    end
    check("sat.total_hits", hits, 7);

    // Randomized traffic on all three instances, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      lv0   = ($urandom_range(0, 3) != 0);
      lv1   = ($urandom_range(0, 3) != 0);
      lv2   = ($urandom_range(0, 3) != 0);
      d0    = 8'($urandom);
      d1    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      d2    = ($urandom_range(0, 3) == 0) ? 16'hAAAA : 16'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
    repeat (25) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
